dpram_tiled: RTL and testbench
==============================

Name: dpram_tiled

Overview:
- Parametrised true dual-port RAM built by tiling the 1024x32 `dpram` primitive: DWIDTH/32 slices across width, NUM_WORDS/1024 banks across depth.
- Adds per-port enables, read-valid tracking, an optional output register stage and deterministic collision/forwarding rules.
- Reports out-of-range accesses and counts write collisions.
- Drop-in storage for activation and weight buffers wider or deeper than 1024x64.

Parameters:
- DWIDTH, 64, data width; must be a multiple of 32.
- AWIDTH, 11, address width.
- NUM_WORDS, 2048, depth; must be a multiple of 1024 and <= 2^AWIDTH.
- OUT_REG, 0, 1 adds a registered output stage (+1 cycle read latency).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- en_a  input  1  port A access enable.
- wren_a  input  1  port A write (qualified by en_a).
- address_a  input  AWIDTH  port A word address.
- data_a  input  DWIDTH  port A write data.
- out_a  output  DWIDTH  port A read data.
- valid_a  output  1  out_a holds the result of an access.
- en_b, wren_b, address_b, data_b, out_b, valid_b: same as port A, for port B.
- oob_a, oob_b  output  1  registered out-of-range flag, aligned with valid_x.
- collision_count  output  16  saturating count of same-address dual writes.

Behaviour:
- Latency L = 1 + OUT_REG.
  - An access accepted in cycle N (en_x=1) produces out_x/valid_x/oob_x in cycle N+L.
  - valid_x=1 for exactly one cycle per access.
  - Back-to-back accesses every cycle are supported; throughput is 1 per port per cycle.
- en_x=0: no read, no write. valid_x goes to 0 after L cycles; out_x holds its last value.
- Bank decode:
  - bank = address[AWIDTH-1:10]; only the selected bank's slices receive wren.
  - The bank select is pipelined alongside the read to drive the output mux.
- Write: en_x & wren_x & in-range stores data_x at address_x. Write-through: out_x at N+L = data_x.
- Read: out_x at N+L = memory contents before any cycle-N write, except for the forwarding rule below.
- Cross-port forwarding:
  - Port A reads X in cycle N while port B writes X in cycle N: out_a = data_b.
  - Symmetric for port B reading while port A writes.
- Write collision:
  - Both ports write the same in-range address in the same cycle: port A wins and port B's write is suppressed.
  - Both out_a and out_b return data_a.
  - collision_count increments by 1 and saturates at 16'hFFFF.
- Out-of-range (address >= NUM_WORDS):
  - Write is dropped.
  - Read returns all zeros.
  - oob_x=1 with valid_x.
  - Never causes a collision or a forward.
- Reset:
  - On reset=1 at a clock edge: out_a, out_b, valid_a, valid_b, oob_a, oob_b, collision_count and all pipeline registers clear to 0.
  - Memory contents are not cleared.
  - Accesses in flight when reset asserts are discarded: no valid is produced for them.
  - Writes presented in a reset cycle are not performed.
- Parameter checks: DWIDTH%32 != 0, NUM_WORDS%1024 != 0, or NUM_WORDS > 2^AWIDTH must fail elaboration (generate-time error).

Test Plan:
- OUT_REG=0, defaults: write A addr 5 = 64'h1111_2222_3333_4444 → valid_a and out_a = same value at N+1. Read B addr 5 at N+1 → out_b = 64'h1111_2222_3333_4444 at N+2.
- Bank crossing: write A addr 1023 = 64'hAA, write B addr 1024 = 64'hBB, then read both on both ports → 1023 returns AA and 1024 returns BB. No aliasing between banks.
- Same-cycle dual write to addr 7: A = 64'h1, B = 64'h2 → both outputs = 1, later read of 7 = 1, collision_count = 1. Repeat 70000 times → count saturates at 65535.
- Forwarding: A reads addr 9 (old 64'h0) while B writes 64'hDEAD to addr 9 → out_a = 64'hDEAD.
- Out-of-range, AWIDTH=12, NUM_WORDS=2048: write addr 3000 then read addr 3000 → out = 0 with oob = 1, memory unchanged; address 3000 mod 2048 = 952 is not modified.
- OUT_REG=1 streaming: 8 consecutive reads → 8 consecutive valids starting at N+2. Assert reset during the stream → valid drops the next cycle, no further valids appear, and memory data is retained after reset.

Source files
------------

// File: rtl/dpram_tiled_if.sv
// One access port of the tiled dual-port RAM: the request side (en/wren/address/data)
// and the response side (out/valid/oob).
interface dpram_tiled_if #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 11
);
    logic              en;
    logic              wren;
    logic [AWIDTH-1:0] address;
    logic [DWIDTH-1:0] data;
    logic [DWIDTH-1:0] out;
    logic              valid;
    logic              oob;

    modport master (output en, wren, address, data, input out, valid, oob);
    modport slave  (input en, wren, address, data, output out, valid, oob);
endinterface

// File: rtl/dpram_tiled.sv
// True dual-port RAM tiled from 1024x32 slices: DWIDTH/32 slices per bank, NUM_WORDS/1024 banks,
// with collision arbitration (port A wins), cross-port forwarding and out-of-range reporting.
module dpram_tiled #(
    parameter int DWIDTH    = 64,
    parameter int AWIDTH    = 11,
    parameter int NUM_WORDS = 2048,
    parameter int OUT_REG   = 0
) (
    input  logic           clk,
    input  logic           reset,
    dpram_tiled_if.slave   port_a,
    dpram_tiled_if.slave   port_b,
    output logic [15:0]    collision_count
);
    localparam int NS    = DWIDTH / 32;
    localparam int NB    = NUM_WORDS / 1024;
    localparam int BW    = (AWIDTH > 10) ? AWIDTH - 10 : 1;
    localparam int SLOTS = 1 << BW;
    localparam logic [AWIDTH:0] LIMIT = NUM_WORDS[AWIDTH:0];

    if (DWIDTH % 32 != 0) begin : g_chk_dwidth
        $error("dpram_tiled: DWIDTH must be a multiple of 32");
    end
    if (NUM_WORDS % 1024 != 0) begin : g_chk_depth
        $error("dpram_tiled: NUM_WORDS must be a multiple of 1024");
    end
    if (NUM_WORDS > (1 << AWIDTH)) begin : g_chk_awidth
        $error("dpram_tiled: NUM_WORDS exceeds the address space");
    end

    logic          inr_a, inr_b, wr_a, wr_b, same_addr, collide, we_a, we_b;
    logic [BW-1:0] bank_a, bank_b;
    logic [9:0]    row_a, row_b;

    if (AWIDTH > 10) begin : g_bank_dec
        assign bank_a = port_a.address[AWIDTH-1:10];
        assign bank_b = port_b.address[AWIDTH-1:10];
    end else begin : g_one_bank
        assign bank_a = '0;
        assign bank_b = '0;
    end

    assign row_a     = port_a.address[9:0];
    assign row_b     = port_b.address[9:0];
    assign inr_a     = {1'b0, port_a.address} < LIMIT;
    assign inr_b     = {1'b0, port_b.address} < LIMIT;
    assign wr_a      = port_a.en & port_a.wren & inr_a;
    assign wr_b      = port_b.en & port_b.wren & inr_b;
    assign same_addr = port_a.address == port_b.address;
    assign collide   = wr_a & wr_b & same_addr;
    assign we_a      = wr_a & ~reset;
    assign we_b      = wr_b & ~collide & ~reset;

    // Unpopulated bank slots read as zero so the output mux index is always in range.
    logic [SLOTS-1:0][DWIDTH-1:0] bank_q_a, bank_q_b;

    for (genvar b = 0; b < SLOTS; b++) begin : g_bank
        if (b < NB) begin : g_mem
            logic sel_a, sel_b;
            assign sel_a = bank_a == BW'(b);
            assign sel_b = bank_b == BW'(b);
            for (genvar s = 0; s < NS; s++) begin : g_slice
                logic [31:0] mem [1024];
                logic [31:0] q_a, q_b;
                // NOTE: the array and its read latches have no reset; contents survive
                // reset, and non-blocking reads return the word as it was before this
                // edge's write, which gives read-before-write without extra logic.
                always_ff @(posedge clk) begin
                    if (we_a && sel_a) mem[row_a] <= port_a.data[32*s +: 32];
                    if (we_b && sel_b) mem[row_b] <= port_b.data[32*s +: 32];
                    if (port_a.en && sel_a) q_a <= mem[row_a];
                    if (port_b.en && sel_b) q_b <= mem[row_b];
                end
                assign bank_q_a[b][32*s +: 32] = q_a;
                assign bank_q_b[b][32*s +: 32] = q_b;
            end
        end else begin : g_empty
            assign bank_q_a[b] = '0;
            assign bank_q_b[b] = '0;
        end
    end

    // Anything that is not a plain read of the array is resolved at request time
    // and carried as bypass data; use_mem selects the array output instead.
    logic              use_mem_a, use_mem_b;
    logic [DWIDTH-1:0] byp_a, byp_b;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        use_mem_a = 1'b0;
        byp_a     = '0;
        if (!inr_a)               byp_a = '0;
        else if (wr_a)            byp_a = port_a.data;
        else if (wr_b && same_addr) byp_a = port_b.data;
        else                      use_mem_a = 1'b1;
    end

    always_comb begin
        use_mem_b = 1'b0;
        byp_b     = '0;
        if (!inr_b)               byp_b = '0;
        else if (collide)         byp_b = port_a.data;
        else if (wr_b)            byp_b = port_b.data;
        else if (wr_a && same_addr) byp_b = port_a.data;
        else                      use_mem_b = 1'b1;
    end

    logic              v1_a, v1_b, oob1_a, oob1_b, mem1_a, mem1_b;
    logic [BW-1:0]     bank1_a, bank1_b;
    logic [DWIDTH-1:0] byp1_a, byp1_b, res_a, res_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_a    <= 1'b0;  v1_b    <= 1'b0;
            oob1_a  <= 1'b0;  oob1_b  <= 1'b0;
            mem1_a  <= 1'b0;  mem1_b  <= 1'b0;
            bank1_a <= '0;    bank1_b <= '0;
            byp1_a  <= '0;    byp1_b  <= '0;
        end else begin
            v1_a   <= port_a.en;
            v1_b   <= port_b.en;
            oob1_a <= port_a.en & ~inr_a;
            oob1_b <= port_b.en & ~inr_b;
            if (port_a.en) begin
                mem1_a  <= use_mem_a;
                bank1_a <= bank_a;
                byp1_a  <= byp_a;
            end
            if (port_b.en) begin
                mem1_b  <= use_mem_b;
                bank1_b <= bank_b;
                byp1_b  <= byp_b;
            end
        end
    end

    assign res_a = mem1_a ? bank_q_a[bank1_a] : byp1_a;
    assign res_b = mem1_b ? bank_q_b[bank1_b] : byp1_b;

    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk) begin
            if (reset) begin
                port_a.valid <= 1'b0;  port_b.valid <= 1'b0;
                port_a.oob   <= 1'b0;  port_b.oob   <= 1'b0;
                port_a.out   <= '0;    port_b.out   <= '0;
            end else begin
                port_a.valid <= v1_a;
                port_b.valid <= v1_b;
                port_a.oob   <= oob1_a;
                port_b.oob   <= oob1_b;
                if (v1_a) port_a.out <= res_a;
                if (v1_b) port_b.out <= res_b;
            end
        end
    end else begin : g_out_direct
        assign port_a.out   = res_a;
        assign port_b.out   = res_b;
        assign port_a.valid = v1_a;
        assign port_b.valid = v1_b;
        assign port_a.oob   = oob1_a;
        assign port_b.oob   = oob1_b;
    end

    always_ff @(posedge clk) begin
        if (reset)                                       collision_count <= '0;
        else if (collide && collision_count != 16'hFFFF) collision_count <= collision_count + 16'd1;
    end
endmodule

// File: tb/tb_dpram_tiled.sv
// Directed bench: u0 is the default configuration (OUT_REG=0), u1 uses AWIDTH=12 and
// OUT_REG=1 for out-of-range and streaming/reset sequences.
module tb_dpram_tiled;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [15:0] cc0, cc1;
    int          n_vec = 0;
    int          n_err = 0;

    dpram_tiled_if #(.DWIDTH(64), .AWIDTH(11)) a0 ();
    dpram_tiled_if #(.DWIDTH(64), .AWIDTH(11)) b0 ();
    dpram_tiled_if #(.DWIDTH(64), .AWIDTH(12)) a1 ();
    dpram_tiled_if #(.DWIDTH(64), .AWIDTH(12)) b1 ();

    dpram_tiled #(.DWIDTH(64), .AWIDTH(11), .NUM_WORDS(2048), .OUT_REG(0)) u0 (
        .clk(clk), .reset(rst0), .port_a(a0), .port_b(b0), .collision_count(cc0));
    dpram_tiled #(.DWIDTH(64), .AWIDTH(12), .NUM_WORDS(2048), .OUT_REG(1)) u1 (
        .clk(clk), .reset(rst1), .port_a(a1), .port_b(b1), .collision_count(cc1));

    localparam logic [63:0] D5 = 64'h1111_2222_3333_4444;

    typedef struct {
        logic        en_a, wr_a;
        logic [10:0] ad_a;
        logic [63:0] d_a;
        logic        en_b, wr_b;
        logic [10:0] ad_b;
        logic [63:0] d_b;
        logic        ev_a;
        logic [63:0] eo_a;
        logic        ev_b;
        logic [63:0] eo_b;
        logic [15:0] ecc;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive0(input logic ea, input logic wa, input logic [10:0] aa, input logic [63:0] da,
                          input logic eb, input logic wb, input logic [10:0] ab, input logic [63:0] db);
        a0.en = ea; a0.wren = wa; a0.address = aa; a0.data = da;
        b0.en = eb; b0.wren = wb; b0.address = ab; b0.data = db;
    endtask

    task automatic collide_n(input int n);
        drive0(1'b1, 1'b1, 11'd7, 64'h1, 1'b1, 1'b1, 11'd7, 64'h2);
        repeat (n) @(posedge clk);
        #1;
        drive0(1'b0, 1'b0, 11'd0, 64'h0, 1'b0, 1'b0, 11'd0, 64'h0);
    endtask

    // One u1 port-A cycle; on return the outputs reflect the access made one call earlier.
    task automatic cyc1(input logic r, input logic en, input logic wr,
                        input logic [11:0] ad, input logic [63:0] d);
        rst1 = r; a1.en = en; a1.wren = wr; a1.address = ad; a1.data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           en_a  wr_a  ad_a        d_a           en_b  wr_b  ad_b        d_b            ev_a eo_a          ev_b eo_b          cc
        vecs[0]  = '{1'b1, 1'b1, 11'd5,    D5,           1'b0, 1'b0, 11'd0,    64'h0,         1'b1, D5,           1'b0, 64'h0,        16'd0};
        vecs[1]  = '{1'b0, 1'b0, 11'd0,    64'h0,        1'b1, 1'b0, 11'd5,    64'h0,         1'b0, D5,           1'b1, D5,           16'd0};
        vecs[2]  = '{1'b1, 1'b1, 11'd1023, 64'hAA,       1'b1, 1'b1, 11'd1024, 64'hBB,        1'b1, 64'hAA,       1'b1, 64'hBB,       16'd0};
        vecs[3]  = '{1'b1, 1'b0, 11'd1024, 64'h0,        1'b1, 1'b0, 11'd1023, 64'h0,         1'b1, 64'hBB,       1'b1, 64'hAA,       16'd0};
        vecs[4]  = '{1'b1, 1'b0, 11'd1023, 64'h0,        1'b1, 1'b0, 11'd1024, 64'h0,         1'b1, 64'hAA,       1'b1, 64'hBB,       16'd0};
        vecs[5]  = '{1'b1, 1'b1, 11'd7,    64'h1,        1'b1, 1'b1, 11'd7,    64'h2,         1'b1, 64'h1,        1'b1, 64'h1,        16'd1};
        vecs[6]  = '{1'b1, 1'b0, 11'd7,    64'h0,        1'b1, 1'b0, 11'd7,    64'h0,         1'b1, 64'h1,        1'b1, 64'h1,        16'd1};
        vecs[7]  = '{1'b1, 1'b1, 11'd9,    64'h0,        1'b0, 1'b0, 11'd0,    64'h0,         1'b1, 64'h0,        1'b0, 64'h1,        16'd1};
        vecs[8]  = '{1'b1, 1'b0, 11'd9,    64'h0,        1'b1, 1'b1, 11'd9,    64'hDEAD,      1'b1, 64'hDEAD,     1'b1, 64'hDEAD,     16'd1};
        vecs[9]  = '{1'b1, 1'b0, 11'd9,    64'h0,        1'b1, 1'b0, 11'd9,    64'h0,         1'b1, 64'hDEAD,     1'b1, 64'hDEAD,     16'd1};
        vecs[10] = '{1'b1, 1'b1, 11'd9,    64'hBEEF,     1'b1, 1'b0, 11'd9,    64'h0,         1'b1, 64'hBEEF,     1'b1, 64'hBEEF,     16'd1};
        vecs[11] = '{1'b0, 1'b0, 11'd0,    64'h0,        1'b0, 1'b0, 11'd0,    64'h0,         1'b0, 64'hBEEF,     1'b0, 64'hBEEF,     16'd1};
        vecs[12] = '{1'b1, 1'b0, 11'd1023, 64'h0,        1'b1, 1'b0, 11'd5,    64'h0,         1'b1, 64'hAA,       1'b1, D5,           16'd1};
        vecs[13] = '{1'b1, 1'b0, 11'd7,    64'h0,        1'b1, 1'b0, 11'd1024, 64'h0,         1'b1, 64'h1,        1'b1, 64'hBB,       16'd1};

        rst0 = 1'b1; rst1 = 1'b1;
        drive0(1'b0, 1'b0, 11'd0, 64'h0, 1'b0, 1'b0, 11'd0, 64'h0);
        a1.en = 1'b0; a1.wren = 1'b0; a1.address = '0; a1.data = '0;
        b1.en = 1'b0; b1.wren = 1'b0; b1.address = '0; b1.data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;

        check ("reset u0 out_a", a0.out, 64'h0);
        check ("reset u0 out_b", b0.out, 64'h0);
        checkb("reset u0 valid_a", a0.valid, 1'b0);
        checkb("reset u0 valid_b", b0.valid, 1'b0);
        checkb("reset u0 oob_a", a0.oob, 1'b0);
        check ("reset u0 cc", 64'(cc0), 64'h0);
        check ("reset u1 out_a", a1.out, 64'h0);
        checkb("reset u1 valid_a", a1.valid, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive0(vecs[i].en_a, vecs[i].wr_a, vecs[i].ad_a, vecs[i].d_a,
                   vecs[i].en_b, vecs[i].wr_b, vecs[i].ad_b, vecs[i].d_b);
            @(posedge clk);
            #1;
            checkb($sformatf("v%0d valid_a", i), a0.valid, vecs[i].ev_a);
            check ($sformatf("v%0d out_a", i), a0.out, vecs[i].eo_a);
            checkb($sformatf("v%0d valid_b", i), b0.valid, vecs[i].ev_b);
            check ($sformatf("v%0d out_b", i), b0.out, vecs[i].eo_b);
            check ($sformatf("v%0d collision_count", i), 64'(cc0), 64'(vecs[i].ecc));
        end
        drive0(1'b0, 1'b0, 11'd0, 64'h0, 1'b0, 1'b0, 11'd0, 64'h0);

        // Saturation: count is 1 here; 65533 more collisions reach 16'hFFFE.
        collide_n(65533);
        check("cc before saturation", 64'(cc0), 64'hFFFE);
        collide_n(1);
        check("cc saturates", 64'(cc0), 64'hFFFF);
        collide_n(5);
        check("cc holds at max", 64'(cc0), 64'hFFFF);
        drive0(1'b1, 1'b0, 11'd7, 64'h0, 1'b1, 1'b0, 11'd7, 64'h0);
        @(posedge clk);
        #1;
        check("addr7 after collisions A", a0.out, 64'h1);
        check("addr7 after collisions B", b0.out, 64'h1);
        drive0(1'b0, 1'b0, 11'd0, 64'h0, 1'b0, 1'b0, 11'd0, 64'h0);

        // u1, OUT_REG=1: fill 100..107 with back-to-back writes (write-through at N+2).
        for (int i = 0; i < 8; i++) begin
            cyc1(1'b0, 1'b1, 1'b1, 12'(100 + i), 64'hC0DE_0000 + 64'(i));
            if (i == 0) checkb("wr stream lat", a1.valid, 1'b0);
            else begin
                checkb($sformatf("wr stream %0d valid", i - 1), a1.valid, 1'b1);
                check ($sformatf("wr stream %0d out", i - 1), a1.out, 64'hC0DE_0000 + 64'(i - 1));
            end
        end
        cyc1(1'b0, 1'b0, 1'b0, 12'd0, 64'h0);
        check("wr stream 7 out", a1.out, 64'hC0DE_0007);
        cyc1(1'b0, 1'b0, 1'b0, 12'd0, 64'h0);
        checkb("wr stream end valid", a1.valid, 1'b0);
        check ("wr stream end hold", a1.out, 64'hC0DE_0007);

        for (int i = 0; i < 8; i++) begin
            cyc1(1'b0, 1'b1, 1'b0, 12'(100 + i), 64'h0);
            if (i == 0) checkb("rd stream lat", a1.valid, 1'b0);
            else begin
                checkb($sformatf("rd stream %0d valid", i - 1), a1.valid, 1'b1);
                check ($sformatf("rd stream %0d out", i - 1), a1.out, 64'hC0DE_0000 + 64'(i - 1));
            end
        end
        cyc1(1'b0, 1'b0, 1'b0, 12'd0, 64'h0);
        checkb("rd stream 7 valid", a1.valid, 1'b1);
        check ("rd stream 7 out", a1.out, 64'hC0DE_0007);
        cyc1(1'b0, 1'b0, 1'b0, 12'd0, 64'h0);
        checkb("rd stream end valid", a1.valid, 1'b0);

        // Out-of-range: 3000 is past NUM_WORDS; 3000 mod 2048 = 952 must stay intact.
        cyc1(1'b0, 1'b1, 1'b1, 12'd952, 64'h0952);
        cyc1(1'b0, 1'b1, 1'b1, 12'd3000, 64'hBAD);
        check ("oob wr952 out", a1.out, 64'h0952);
        checkb("oob wr952 flag", a1.oob, 1'b0);
        cyc1(1'b0, 1'b1, 1'b0, 12'd3000, 64'h0);
        checkb("oob wr3000 valid", a1.valid, 1'b1);
        check ("oob wr3000 out", a1.out, 64'h0);
        checkb("oob wr3000 flag", a1.oob, 1'b1);
        cyc1(1'b0, 1'b1, 1'b0, 12'd952, 64'h0);
        check ("oob rd3000 out", a1.out, 64'h0);
        checkb("oob rd3000 flag", a1.oob, 1'b1);
        cyc1(1'b0, 1'b0, 1'b0, 12'd0, 64'h0);
        check ("oob rd952 out", a1.out, 64'h0952);
        checkb("oob rd952 flag", a1.oob, 1'b0);
        checkb("oob no collision", cc1 == 16'd0, 1'b1);

        // Reset mid-stream: in-flight reads vanish, write in the reset cycle is dropped.
        cyc1(1'b0, 1'b1, 1'b0, 12'd100, 64'h0);
        cyc1(1'b0, 1'b1, 1'b0, 12'd101, 64'h0);
        check("pre-reset rd100", a1.out, 64'hC0DE_0000);
        cyc1(1'b0, 1'b1, 1'b0, 12'd102, 64'h0);
        check("pre-reset rd101", a1.out, 64'hC0DE_0001);
        cyc1(1'b1, 1'b1, 1'b1, 12'd104, 64'hFFFF);
        checkb("reset drops valid", a1.valid, 1'b0);
        check ("reset clears out", a1.out, 64'h0);
        cyc1(1'b0, 1'b0, 1'b0, 12'd0, 64'h0);
        checkb("post-reset no valid 1", a1.valid, 1'b0);
        cyc1(1'b0, 1'b1, 1'b0, 12'd105, 64'h0);
        checkb("post-reset no valid 2", a1.valid, 1'b0);
        cyc1(1'b0, 1'b1, 1'b0, 12'd104, 64'h0);
        checkb("retained 105 valid", a1.valid, 1'b1);
        check ("retained 105", a1.out, 64'hC0DE_0005);
        cyc1(1'b0, 1'b0, 1'b0, 12'd0, 64'h0);
        check ("reset-cycle write dropped", a1.out, 64'hC0DE_0004);
        checkb("port B idle valid", b1.valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
